// File: rtl/dds_two_tone_gen_if.sv
`default_nettype none
// =============================================================================
// Module   : dds_two_tone_gen_if
// Brief    : Filter sample interface: signed sample plus one-cycle valid strobe.
// Revision : 1.0
// =============================================================================
interface dds_two_tone_gen_if #(
  parameter int NB_SAMPLE = 9
) ();
  logic signed [NB_SAMPLE-1:0] sample;
  logic                        valid;

  modport master (output sample, output valid);
  modport slave  (input  sample, input  valid);
endinterface
`default_nettype wire

// File: rtl/dds_two_tone_gen.sv
`default_nettype none
// =============================================================================
// Module   : dds_two_tone_gen
// Brief    : Two-tone DDS source: tone A + shifted tone B, saturated, one
//            sample per programmable period through a 3-stage pipeline.
// Revision : 1.0
// =============================================================================
module dds_two_tone_gen #(
  parameter int NB_SAMPLE  = 9,
  parameter int NBF_SAMPLE = 7,
  parameter int NB_PHASE   = 16,
  parameter int NB_DIV     = 8
) (
  input  wire                  clock,
  input  wire                  i_reset,
  input  wire                  i_enable,
  input  wire [NB_PHASE-1:0]   i_phase_inc_a,
  input  wire [NB_PHASE-1:0]   i_phase_inc_b,
  input  wire [1:0]            i_shift_b,
  input  wire [NB_DIV-1:0]     i_div,
  dds_two_tone_gen_if.master   o_smp
);

  localparam int     c_qw      = NBF_SAMPLE + 1;
  localparam longint c_pi_q30  = 64'sd3373259426;

  // Quarter-wave table built at elaboration with Q30 integer Taylor series of
  // sin(pi*(2k+1)/1024), rounded to NBF_SAMPLE fractional bits.
  function automatic logic [256*c_qw-1:0] f_build_qtab();
    logic [256*c_qw-1:0] tab;
    longint x, x2, term, acc, q;
    tab = '0;
    for (int k = 0; k < 256; k++) begin
      x    = (c_pi_q30 * longint'(2 * k + 1)) >>> 10;
      x2   = (x * x) >>> 30;
      term = x;
      acc  = x;
      for (int n = 1; n <= 8; n++) begin
        term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
        acc  = acc + term;
      end
      q = ((acc <<< NBF_SAMPLE) + (64'sd1 <<< 29)) >>> 30;
      tab[k*c_qw +: c_qw] = q[c_qw-1:0];
    end
    return tab;
  endfunction

  localparam logic [256*c_qw-1:0] c_qtab = f_build_qtab();

  logic [NB_DIV-1:0]           r_count;
  logic [NB_PHASE-1:0]         r_phase_a;
  logic [NB_PHASE-1:0]         r_phase_b;
  logic                        r_s1_valid;
  logic                        r_s1_neg_a;
  logic                        r_s1_neg_b;
  logic [7:0]                  r_s1_addr_a;
  logic [7:0]                  r_s1_addr_b;
  logic                        r_s2_valid;
  logic signed [NB_SAMPLE-1:0] r_sa;
  logic signed [NB_SAMPLE-1:0] r_sb;

  logic                        w_tick;
  logic [7:0]                  w_k_a;
  logic [7:0]                  w_k_b;
  logic [c_qw-1:0]             w_qa;
  logic [c_qw-1:0]             w_qb;
  logic signed [NB_SAMPLE-1:0] w_qa_ext;
  logic signed [NB_SAMPLE-1:0] w_qb_ext;
  logic signed [NB_SAMPLE-1:0] w_sb_sh;
  logic signed [NB_SAMPLE:0]   w_sum;
  logic signed [NB_SAMPLE-1:0] w_sat;

  assign w_tick = i_enable && (r_count == '0);
  assign w_k_a  = r_phase_a[NB_PHASE-3 -: 8];
  assign w_k_b  = r_phase_b[NB_PHASE-3 -: 8];

  // Divider, phase accumulators and S1 (sign bit + mirrored table address)
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_count     <= '0;
      r_phase_a   <= '0;
      r_phase_b   <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_neg_a  <= 1'b0;
      r_s1_neg_b  <= 1'b0;
      r_s1_addr_a <= '0;
      r_s1_addr_b <= '0;
    end else begin
      if (!i_enable)
        r_count <= '0;
      else
        r_count <= (r_count >= i_div) ? '0 : r_count + 1'b1;
      r_s1_valid <= w_tick;
      if (w_tick) begin
        r_phase_a   <= r_phase_a + i_phase_inc_a;
        r_phase_b   <= r_phase_b + i_phase_inc_b;
        r_s1_neg_a  <= r_phase_a[NB_PHASE-1];
        r_s1_neg_b  <= r_phase_b[NB_PHASE-1];
        r_s1_addr_a <= r_phase_a[NB_PHASE-2] ? ~w_k_a : w_k_a;
        r_s1_addr_b <= r_phase_b[NB_PHASE-2] ? ~w_k_b : w_k_b;
      end
    end
  end

  assign w_qa     = c_qtab[int'(r_s1_addr_a)*c_qw +: c_qw];
  assign w_qb     = c_qtab[int'(r_s1_addr_b)*c_qw +: c_qw];
  assign w_qa_ext = {{(NB_SAMPLE-c_qw){1'b0}}, w_qa};
  assign w_qb_ext = {{(NB_SAMPLE-c_qw){1'b0}}, w_qb};

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_s2_valid <= 1'b0;
      r_sa       <= '0;
      r_sb       <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sa <= r_s1_neg_a ? -w_qa_ext : w_qa_ext;
        r_sb <= r_s1_neg_b ? -w_qb_ext : w_qb_ext;
      end
    end
  end

  // One guard bit is enough: disagreement of the top two bits means overflow
  always_comb begin
    w_sb_sh = r_sb >>> i_shift_b;
    w_sum   = {r_sa[NB_SAMPLE-1], r_sa};
    if (i_shift_b != 2'd3)
      w_sum = w_sum + {w_sb_sh[NB_SAMPLE-1], w_sb_sh};
    if (w_sum[NB_SAMPLE] != w_sum[NB_SAMPLE-1])
      w_sat = {w_sum[NB_SAMPLE], {(NB_SAMPLE-1){~w_sum[NB_SAMPLE]}}};
    else
      w_sat = w_sum[NB_SAMPLE-1:0];
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      o_smp.valid  <= 1'b0;
      o_smp.sample <= '0;
    end else begin
      o_smp.valid <= r_s2_valid;
      if (r_s2_valid)
        o_smp.sample <= w_sat;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dds_two_tone_gen.sv
`default_nettype none
// =============================================================================
// Module   : tb_dds_two_tone_gen
// Brief    : Directed self-checking bench for dds_two_tone_gen.
// Revision : 1.0
// =============================================================================
module tb_dds_two_tone_gen;

  logic        clock = 1'b0;
  logic        i_reset;
  logic        i_enable;
  logic [15:0] i_phase_inc_a;
  logic [15:0] i_phase_inc_b;
  logic [1:0]  i_shift_b;
  logic [7:0]  i_div;

  int n_pass  = 0;
  int n_total = 0;

  dds_two_tone_gen_if #(.NB_SAMPLE(9)) smp ();

  dds_two_tone_gen dut (
    .clock         (clock),
    .i_reset       (i_reset),
    .i_enable      (i_enable),
    .i_phase_inc_a (i_phase_inc_a),
    .i_phase_inc_b (i_phase_inc_b),
    .i_shift_b     (i_shift_b),
    .i_div         (i_div),
    .o_smp         (smp)
  );

  always #5 clock = ~clock;

  function automatic int lut_ref(input logic [15:0] ph);
    int  k, idx, q;
    real ang;
    k   = int'(ph[13:6]);
    idx = ph[14] ? 255 - k : k;
    ang = 2.0 * 3.14159265358979 * (real'(idx) + 0.5) / 1024.0;
    q   = $rtoi($sin(ang) * 128.0 + 0.5);
    return ph[15] ? -q : q;
  endfunction

  function automatic int sample_ref(input logic [15:0] pa, input logic [15:0] pb,
                                    input logic [1:0] sh);
    int s;
    s = lut_ref(pa);
    if (sh != 2'd3) s = s + (lut_ref(pb) >>> sh);
    if (s > 255)  s = 255;
    if (s < -256) s = -256;
    return s;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    i_enable = 1'b0;
    i_reset  = 1'b0;
    @(negedge clock);
    i_reset  = 1'b1;
  endtask

  task automatic test_reset();
    int seq [4] = '{0, 128, 0, -128};
    int got, exp;
    logic expv;
    repeat (2) @(negedge clock);
    n_total++;
    if (smp.valid !== 1'b0 || smp.sample !== 9'sd0)
      $display("FAIL reset_state: valid=%b sample=%0d, required valid=0 sample=0", smp.valid, smp.sample);
    else n_pass++;
    i_phase_inc_a = 16'd16384; i_phase_inc_b = 16'd0; i_shift_b = 2'd3; i_div = 8'd0;
    i_reset = 1'b1; i_enable = 1'b1;
    repeat (4) @(negedge clock);
    got = int'(smp.sample);
    n_total++;
    if (smp.valid !== 1'b1 || got !== 128)
      $display("FAIL reset_prerun: valid=%b sample=%0d, required valid=1 sample=128", smp.valid, got);
    else n_pass++;
    @(posedge clock);
    #2 i_reset = 1'b0;
    #1;
    n_total++;
    if (smp.valid !== 1'b0 || smp.sample !== 9'sd0)
      $display("FAIL reset_async: valid=%b sample=%0d, required valid=0 sample=0", smp.valid, smp.sample);
    else n_pass++;
    @(negedge clock);
    i_reset = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clock);
      expv = (n >= 3);
      exp  = (n >= 3) ? seq[(n-3) % 4] : 0;
      got  = int'(smp.sample);
      n_total++;
      if (smp.valid !== expv || got !== exp)
        $display("FAIL reset_restart n=%0d: valid=%b sample=%0d, required valid=%b sample=%0d", n, smp.valid, got, expv, exp);
      else n_pass++;
    end
  endtask

  task automatic test_tone_a();
    int seq [4] = '{0, 128, 0, -128};
    int got, exp;
    logic expv;
    do_reset();
    i_phase_inc_a = 16'd16384; i_phase_inc_b = 16'd0; i_shift_b = 2'd3; i_div = 8'd0;
    i_enable = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clock);
      expv = (n >= 3);
      exp  = (n >= 3) ? seq[(n-3) % 4] : 0;
      got  = int'(smp.sample);
      n_total++;
      if (smp.valid !== expv || got !== exp)
        $display("FAIL tone_a n=%0d: valid=%b sample=%0d, required valid=%b sample=%0d", n, smp.valid, got, expv, exp);
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    int seq [4] = '{0, 255, 0, -256};
    int got, exp;
    logic expv;
    do_reset();
    i_phase_inc_a = 16'd16384; i_phase_inc_b = 16'd16384; i_shift_b = 2'd0; i_div = 8'd0;
    i_enable = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clock);
      expv = (n >= 3);
      exp  = (n >= 3) ? seq[(n-3) % 4] : 0;
      got  = int'(smp.sample);
      n_total++;
      if (smp.valid !== expv || got !== exp)
        $display("FAIL saturation n=%0d: valid=%b sample=%0d, required valid=%b sample=%0d", n, smp.valid, got, expv, exp);
      else n_pass++;
    end
  endtask

  task automatic test_divider();
    int seq [4] = '{0, 128, 0, -128};
    int got, exp, idx;
    logic expv;
    do_reset();
    i_phase_inc_a = 16'd16384; i_phase_inc_b = 16'd0; i_shift_b = 2'd3; i_div = 8'd4;
    i_enable = 1'b1;
    exp = 0;
    idx = 0;
    for (int n = 1; n <= 28; n++) begin
      @(negedge clock);
      expv = (n >= 3) && ((n - 3) % 5 == 0);
      if (expv) begin
        exp = seq[idx % 4];
        idx++;
      end
      got = int'(smp.sample);
      n_total++;
      if (smp.valid !== expv || got !== exp)
        $display("FAIL divider n=%0d: valid=%b sample=%0d, required valid=%b sample=%0d", n, smp.valid, got, expv, exp);
      else n_pass++;
    end
  endtask

  task automatic test_filter_stim();
    logic [15:0] pa, pb;
    int got, exp, cnt, max_abs;
    do_reset();
    i_phase_inc_a = 16'd1365; i_phase_inc_b = 16'd20480; i_shift_b = 2'd1; i_div = 8'd0;
    i_enable = 1'b1;
    pa = '0; pb = '0; cnt = 0; max_abs = 0;
    for (int n = 1; n <= 4006; n++) begin
      @(negedge clock);
      if (n == 4000) i_enable = 1'b0;
      if (smp.valid === 1'b1) begin
        exp = sample_ref(pa, pb, 2'd1);
        got = int'(smp.sample);
        pa  = pa + 16'd1365;
        pb  = pb + 16'd20480;
        if (got > max_abs) max_abs = got;
        if (-got > max_abs) max_abs = -got;
        n_total++;
        if (got !== exp)
          $display("FAIL filter_stim sample=%0d: got %0d, required %0d", cnt, got, exp);
        else n_pass++;
        cnt++;
      end
    end
    n_total++;
    if (cnt !== 4000)
      $display("FAIL filter_count: got %0d samples, required 4000", cnt);
    else n_pass++;
    n_total++;
    if (max_abs > 192)
      $display("FAIL filter_peak: got |sample| %0d, required <= 192", max_abs);
    else n_pass++;
  endtask

  task automatic test_enable_drop();
    logic [15:0] pa, pb;
    int got, exp, cnt;
    logic expv;
    do_reset();
    i_phase_inc_a = 16'd1000; i_phase_inc_b = 16'd7000; i_shift_b = 2'd2; i_div = 8'd0;
    i_enable = 1'b1;
    pa = '0; pb = '0; cnt = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      expv = (n >= 3 && n <= 12) || (n >= 33);
      n_total++;
      if (smp.valid !== expv)
        $display("FAIL enable_drop_valid n=%0d: valid=%b, required %b", n, smp.valid, expv);
      else n_pass++;
      if (smp.valid === 1'b1) begin
        exp = sample_ref(pa, pb, 2'd2);
        got = int'(smp.sample);
        pa  = pa + 16'd1000;
        pb  = pb + 16'd7000;
        n_total++;
        if (got !== exp)
          $display("FAIL enable_drop_sample idx=%0d: got %0d, required %0d", cnt, got, exp);
        else n_pass++;
        cnt++;
      end
      if (n == 10) i_enable = 1'b0;
      if (n == 30) i_enable = 1'b1;
    end
    n_total++;
    if (cnt !== 18)
      $display("FAIL enable_drop_count: got %0d samples, required 18", cnt);
    else n_pass++;
  endtask

  initial begin
    i_reset = 1'b0; i_enable = 1'b0;
    i_phase_inc_a = '0; i_phase_inc_b = '0; i_shift_b = 2'd3; i_div = '0;
    test_reset();
    test_tone_a();
    test_saturation();
    test_divider();
    test_filter_stim();
    test_enable_drop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dds_two_tone_gen.md
Name: dds_two_tone_gen

Overview:
Two-tone direct-digital-synthesis sample source. It is the transmit end of the filter sample interface and feeds x_i of the IIR filter in hardware, in place of bench-generated stimulus. It sums a full-scale tone A and a gain-shifted tone B, saturates the sum to S(NB_SAMPLE,NBF_SAMPLE), and emits one sample per programmable sample period with a valid strobe.

Parameters:
NB_SAMPLE, 9, output sample width (signed)
NBF_SAMPLE, 7, output fractional bits; LUT amplitude 1.0 = 2^NBF_SAMPLE
NB_PHASE, 16, phase accumulator width
NB_DIV, 8, sample-period divider width

Ports:
clock  in  1  system clock
i_reset  in  1  asynchronous active-low reset
i_enable  in  1  run enable
i_phase_inc_a  in  NB_PHASE  tone A phase increment per sample
i_phase_inc_b  in  NB_PHASE  tone B phase increment per sample
i_shift_b  in  2  tone B gain: 0=1, 1=1/2, 2=1/4, 3=muted
i_div  in  NB_DIV  sample period minus 1, in clocks
o_sample  out  NB_SAMPLE  signed sample, S(NB_SAMPLE,NBF_SAMPLE)
o_valid  out  1  one-cycle strobe, o_sample valid

Behaviour:
- Reset (i_reset=0): asynchronous. All registers clear immediately: o_sample=0, o_valid=0, both phase accumulators=0, divider count=0, pipeline valids=0.
- Divider:
  - tick = i_enable && (count==0).
  - While enabled: count <= (count>=i_div) ? 0 : count+1.
  - While disabled: count <= 0.
  - i_div=0 gives a tick every cycle.
  - If i_div is lowered below the current count, the count wraps to 0 on the next cycle.
- On tick:
  - phase_x <= phase_x + i_phase_inc_x, modulo 2^NB_PHASE, no saturation.
  - The emitted sample uses the phase value before the increment. Increments are sampled at the tick only.
- LUT:
  - 256-entry quarter-wave table. Q[k] = round(sin(2*pi*(k+0.5)/1024) * 2^NBF_SAMPLE), k=0..255, unsigned; Q[0]=0, Q[255]=128.
  - Index is the top 10 phase bits: quadrant = bits[NB_PHASE-1:NB_PHASE-2], k = the next 8 bits.
  - Quadrant mapping: q0 -> +Q[k]; q1 -> +Q[255-k]; q2 -> -Q[k]; q3 -> -Q[255-k].
- Pipeline (3 stages, each with its own valid bit):
  - S1: register quadrant and address for both tones.
  - S2: registered LUT read and sign apply, giving sa and sb (NB_SAMPLE signed).
  - S3: sum = sa + (sb >>> i_shift_b), or sum = sa when i_shift_b=3. The sum is NB_SAMPLE+1 bits wide. Saturate to [-2^(NB_SAMPLE-1), 2^(NB_SAMPLE-1)-1], i.e. [-256, 255], then register into o_sample.
- Latency:
  - o_valid rises exactly 3 clocks after the tick cycle and stays high for 1 clock.
  - o_sample holds its last value between strobes.
- i_enable low:
  - No new ticks; phases hold.
  - Samples already in flight (≤3) still drain with o_valid, then o_valid stays 0.
  - Re-enable resumes from the held phases (phase-continuous). The first tick is on the first enabled cycle.
- i_shift_b changing mid-stream applies at S3 in the cycle it is seen. The bench must change it only while idle.

Test Plan:
1. Reset: run, then assert i_reset low mid-stream -> o_sample=0 and o_valid=0 immediately (asynchronous). Release -> phases restart from 0.
2. inc_a=16384, i_shift_b=3, i_div=0, enable -> o_valid every cycle from tick+3; o_sample = 0, 128, 0, -128, repeating.
3. Saturation: inc_a=inc_b=16384, i_shift_b=0, i_div=0 -> o_sample = 0, 255, 0, -256, repeating.
4. Divider: same setup as 2, with i_div=4 -> o_valid pulses one cycle every 5 clocks; same value sequence; o_sample held between pulses.
5. Filter stimulus:
   - Setup: inc_a=1365 (1 kHz at 48 kHz), inc_b=20480 (15 kHz), i_shift_b=1, 4000 samples.
   - Check: bit-exact match to the reference model; |o_sample| ≤ 192.
6. Enable drop: drop i_enable after 10 ticks -> exactly the in-flight samples drain, then o_valid=0. Re-enable after 20 clocks -> the next sample continues the phase sequence, with no restart.
